// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package    : uart_cmd_pkg
// Description: Shared types and helpers for the UART command framer.
//              Provides the parser state encoding, the default sync marker
//              and width helpers for the length and payload-address fields.
// Revision   : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    LEN  = 3'd2,
    PAY  = 3'd3,
    CHK  = 3'd4
  } framer_state_t;

  localparam logic [7:0] SYNC = 8'hA5;

  // Bits needed to hold a payload length in 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Bits needed to index a payload buffer of max_len entries (at least 1).
  function automatic int unsigned addr_w(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_framer_if.sv
`default_nettype none
// ============================================================================
// Interface  : uart_cmd_framer_if
// Description: Byte input, frame handshake, payload read port and error
//              pulses of the UART command framer.
//   rx_done/rx_data         byte from the UART receiver
//   cmd_valid/cmd_ready     frame handshake, cmd_op/cmd_len describe the frame
//   pl_addr/pl_data         combinational payload read of the held frame
//   err_chk/len/tout/ovr    one-cycle error pulses
//   modport master : framer side,  modport slave : receiver/consumer side
// Revision   : 1.0 - initial release
// ============================================================================
interface uart_cmd_framer_if
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8
);
  localparam int unsigned LW = len_w(MAX_LEN);
  localparam int unsigned AW = addr_w(MAX_LEN);

  logic          rx_done;
  logic [7:0]    rx_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic          err_chk;
  logic          err_len;
  logic          err_tout;
  logic          err_ovr;

  modport master (
    input  rx_done, rx_data, cmd_ready, pl_addr,
    output cmd_valid, cmd_op, cmd_len, pl_data,
    output err_chk, err_len, err_tout, err_ovr
  );

  modport slave (
    output rx_done, rx_data, cmd_ready, pl_addr,
    input  cmd_valid, cmd_op, cmd_len, pl_data,
    input  err_chk, err_len, err_tout, err_ovr
  );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module     : uart_cmd_timeout
// Description: Loadable down-counter. Reloads to TIMEOUT_CYC-1 on clear or
//              while disabled, counts down while enabled, and raises expire
//              for the enabled cycle in which the count sits at zero.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : reload the counter
//   en_i         : count enable
//   expire_o     : timeout reached (combinational)
// Revision   : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= LOAD;
    end else if (clear_i || !en_i) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire_o = en_i & ~clear_i & (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module     : uart_cmd_framer
// Description: Parses SYNC,CMD,LEN,payload,CHK frames from a UART byte stream
//              and presents validated frames with a valid/ready handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : uart_cmd_framer_if.master (bytes, handshake, payload, errors)
//   stat_good/stat_bad : frame statistics, only with UART_CMD_STATS_EN
// Optional feature macro: UART_CMD_STATS_EN
// Revision   : 1.0 - initial release
// ============================================================================
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic reset_n,
  uart_cmd_framer_if.master bus
`ifdef UART_CMD_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
`endif
);
  localparam int unsigned LW = len_w(MAX_LEN);
  localparam int unsigned AW = addr_w(MAX_LEN);

  framer_state_t state_q;
  logic          rx_done_q;
  logic [7:0]    chk_q;
  logic [7:0]    cap_op_q;
  logic [LW-1:0] cap_len_q;
  logic [AW-1:0] idx_q;
  logic [7:0]    pl_buf_q [MAX_LEN];
  logic          valid_q;
  logic [7:0]    op_q;
  logic [LW-1:0] len_q;
  logic          err_chk_q, err_len_q, err_tout_q, err_ovr_q;

  logic          w_evt, w_accept, w_drop, w_take, w_tout;
  logic [7:0]    w_byte;
  logic [LW-1:0] w_idx_next;

  // One event per rising edge of the level-type done flag.
  assign w_evt    = bus.rx_done & ~rx_done_q;
  assign w_byte   = bus.rx_data;
  assign w_accept = valid_q & bus.cmd_ready;
  // A frame still pending (and not being accepted this cycle) blocks input.
  assign w_drop   = w_evt & valid_q & ~bus.cmd_ready;
  assign w_take   = w_evt & ~w_drop;
  assign w_idx_next = LW'(idx_q) + LW'(1);

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (w_evt),
    .en_i     (state_q != IDLE),
    .expire_o (w_tout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rx_done_q  <= 1'b0;
      chk_q      <= '0;
      cap_op_q   <= '0;
      cap_len_q  <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      op_q       <= '0;
      len_q      <= '0;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tout_q <= 1'b0;
      err_ovr_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) pl_buf_q[i] <= '0;
    end else begin
      rx_done_q  <= bus.rx_done;
      err_chk_q  <= 1'b0;
      err_len_q  <= 1'b0;
      err_tout_q <= 1'b0;
      err_ovr_q  <= 1'b0;
      if (w_accept) valid_q <= 1'b0;

      if (w_drop) begin
        err_ovr_q <= 1'b1;
      end else if (w_tout) begin
        // Expiry never coincides with a byte event (the event clears it).
        state_q    <= IDLE;
        err_tout_q <= 1'b1;
      end else if (w_take) begin
        case (state_q)
          IDLE: if (w_byte == SYNC_BYTE) state_q <= CMD;
          CMD: begin
            cap_op_q <= w_byte;
            chk_q    <= w_byte;
            state_q  <= LEN;
          end
          LEN: begin
            chk_q     <= chk_q ^ w_byte;
            cap_len_q <= w_byte[LW-1:0];
            idx_q     <= '0;
            if (32'(w_byte) > MAX_LEN) begin
              state_q   <= IDLE;
              err_len_q <= 1'b1;
            end else if (w_byte == 8'd0) begin
              state_q <= CHK;
            end else begin
              state_q <= PAY;
            end
          end
          PAY: begin
            pl_buf_q[idx_q] <= w_byte;
            chk_q           <= chk_q ^ w_byte;
            idx_q           <= idx_q + AW'(1);
            if (w_idx_next == cap_len_q) state_q <= CHK;
          end
          CHK: begin
            state_q <= IDLE;
            if (w_byte == chk_q) begin
              valid_q <= 1'b1;
              op_q    <= cap_op_q;
              len_q   <= cap_len_q;
            end else begin
              err_chk_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_op    = op_q;
  assign bus.cmd_len   = len_q;
  assign bus.pl_data   = (32'(bus.pl_addr) < MAX_LEN) ? pl_buf_q[bus.pl_addr] : 8'h00;
  assign bus.err_chk   = err_chk_q;
  assign bus.err_len   = err_len_q;
  assign bus.err_tout  = err_tout_q;
  assign bus.err_ovr   = err_ovr_q;

`ifdef UART_CMD_STATS_EN
  logic        valid_d1_q;
  logic [15:0] good_q, bad_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_d1_q <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      valid_d1_q <= valid_q;
      if (valid_q && !valid_d1_q && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      if ((err_chk_q || err_len_q || err_tout_q) && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
    end
  end

  assign stat_good = good_q;
  assign stat_bad  = bad_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module     : tb_uart_cmd_framer
// Description: Directed self-checking bench for uart_cmd_framer
//              (MAX_LEN=8, shortened TIMEOUT_CYC=64).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_framer;
  localparam int unsigned MAX_LEN     = 8;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_chk = 0, n_len = 0, n_tout = 0, n_ovr = 0;

  uart_cmd_framer_if #(.MAX_LEN(MAX_LEN)) bus ();

`ifdef UART_CMD_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif

  uart_cmd_framer #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef UART_CMD_STATS_EN
    ,
    .stat_good (stat_good),
    .stat_bad  (stat_bad)
`endif
  );

  always #5 clk = ~clk;

  // Error pulse tallies, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.err_chk)  n_chk++;
    if (bus.err_len)  n_len++;
    if (bus.err_tout) n_tout++;
    if (bus.err_ovr)  n_ovr++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pl(input logic [2:0] a, input logic [7:0] exp, input string tag);
    bus.pl_addr = a;
    #1;
    check(tag, 16'(bus.pl_data), 16'(exp));
  endtask

  task automatic accept();
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    check("valid_after_accept", 16'(bus.cmd_valid), 16'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.cmd_ready = 1'b0;
    bus.pl_addr = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(bus.cmd_valid), 16'd0);
    check("rst_op",    16'(bus.cmd_op),    16'd0);
    check("rst_len",   16'(bus.cmd_len),   16'd0);
    check("rst_errs",  16'({bus.err_chk, bus.err_len, bus.err_tout, bus.err_ovr}), 16'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame: 10^02^33^44 = 65
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44);
    check("valid_before_chk", 16'(bus.cmd_valid), 16'd0);
    send(8'h65);
    check("f1_valid", 16'(bus.cmd_valid), 16'd1);
    check("f1_op",    16'(bus.cmd_op),    16'h10);
    check("f1_len",   16'(bus.cmd_len),   16'd2);
    pl(3'd0, 8'h33, "f1_pl0");
    pl(3'd1, 8'h44, "f1_pl1");
    accept();

    // Bad checksum, then a good frame: 20^01^7E = 5F
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
    check("badchk_errcnt", 16'(n_chk), 16'd1);
    check("badchk_valid",  16'(bus.cmd_valid), 16'd0);
    send(8'hA5); send(8'h20); send(8'h01); send(8'h7E); send(8'h5F);
    check("f2_valid", 16'(bus.cmd_valid), 16'd1);
    check("f2_op",    16'(bus.cmd_op),    16'h20);
    check("f2_len",   16'(bus.cmd_len),   16'd1);
    pl(3'd0, 8'h7E, "f2_pl0");
    accept();

    // LEN 9 > MAX_LEN, then a zero-length frame: 01^00 = 01
    send(8'hA5); send(8'h01); send(8'h09);
    check("len_errcnt", 16'(n_len), 16'd1);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    check("f3_valid", 16'(bus.cmd_valid), 16'd1);
    check("f3_op",    16'(bus.cmd_op),    16'h01);
    check("f3_len",   16'(bus.cmd_len),   16'd0);
    check("len_errcnt_after", 16'(n_len), 16'd1);
    accept();

    // Inter-byte timeout after A5 10
    send(8'hA5); send(8'h10);
    repeat (50) @(negedge clk);
    check("tout_early", 16'(n_tout), 16'd0);
    repeat (20) @(negedge clk);
    check("tout_fired", 16'(n_tout), 16'd1);
    repeat (100) @(negedge clk);
    check("tout_once", 16'(n_tout), 16'd1);
    send(8'hA5); send(8'h33); send(8'h00); send(8'h33);
    check("f4_valid", 16'(bus.cmd_valid), 16'd1);
    check("f4_op",    16'(bus.cmd_op),    16'h33);
    accept();

    // Pending frame with ready low: 42^03^01^02^03 = 41
    send(8'hA5); send(8'h42); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h41);
    check("f5_valid", 16'(bus.cmd_valid), 16'd1);
    send(8'hA5); send(8'h42); send(8'h00);
    check("ovr_errcnt", 16'(n_ovr), 16'd3);
    check("ovr_valid",  16'(bus.cmd_valid), 16'd1);
    check("ovr_op",     16'(bus.cmd_op),    16'h42);
    check("ovr_len",    16'(bus.cmd_len),   16'd3);
    pl(3'd0, 8'h01, "ovr_pl0");
    pl(3'd2, 8'h03, "ovr_pl2");

    // Accept and SYNC byte event in the same cycle: the byte is parsed.
    @(negedge clk);
    bus.cmd_ready = 1'b1;
    bus.rx_data   = 8'hA5;
    bus.rx_done   = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    @(negedge clk);
    bus.rx_done   = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h55); send(8'h00); send(8'h55);
    check("simul_valid", 16'(bus.cmd_valid), 16'd1);
    check("simul_op",    16'(bus.cmd_op),    16'h55);
    check("simul_ovr",   16'(n_ovr),         16'd3);
    accept();

    // rx_done held high for 1000 cycles: one A5 event, then a timeout.
    @(negedge clk);
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    repeat (1000) @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_len_errs", 16'(n_len),  16'd1);
    check("hold_touts",    16'(n_tout), 16'd2);
    send(8'hA5); send(8'h66); send(8'h00); send(8'h66);
    check("f6_valid", 16'(bus.cmd_valid), 16'd1);
    check("f6_op",    16'(bus.cmd_op),    16'h66);

    // Reset mid-PAY with a frame still pending beforehand accepted away.
    accept();
    send(8'hA5); send(8'h77); send(8'h04); send(8'h11); send(8'h22);
    @(negedge clk);
    reset_n = 1'b0;
    bus.pl_addr = 3'd0;
    #1;
    check("midrst_valid", 16'(bus.cmd_valid), 16'd0);
    check("midrst_op",    16'(bus.cmd_op),    16'd0);
    check("midrst_len",   16'(bus.cmd_len),   16'd0);
    check("midrst_pl0",   16'(bus.pl_data),   16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_errs", 16'(n_chk + n_len + n_tout + n_ovr), 16'd7);
    // 05^01^AA = AE
    send(8'hA5); send(8'h05); send(8'h01); send(8'hAA); send(8'hAE);
    check("f7_valid", 16'(bus.cmd_valid), 16'd1);
    check("f7_op",    16'(bus.cmd_op),    16'h05);
    check("f7_len",   16'(bus.cmd_len),   16'd1);
    pl(3'd0, 8'hAA, "f7_pl0");
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
